// File: rtl/mem_arbiter_if.sv
// Requester-side bundle for mem_arbiter: IF fetch channel and MEM load/store channel.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_done;
  logic [31:0]           if_data;
  logic [1:0]            mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [1:0]            mem_width;
  logic [31:0]           mem_wdata;
  logic                  mem_done;
  logic [31:0]           mem_rdata;

  modport master (
    output if_req, if_addr, mem_req, mem_addr, mem_width, mem_wdata,
    input  if_done, if_data, mem_done, mem_rdata
  );

  modport slave (
    input  if_req, if_addr, mem_req, mem_addr, mem_width, mem_wdata,
    output if_done, if_data, mem_done, mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises IF fetches and MEM loads/stores into little-endian byte accesses on
// a byte-wide RAM/IO port. Define MEM_ARB_IO_WAIT_EN to stall IO-region writes while io_buffer_full.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [1:0]  IO_SEL     = 2'b11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  mem_arbiter_if.slave          bus,
  output logic                  busy,
  input  logic                  io_buffer_full,
  input  logic [7:0]            ram_data_i,
  output logic [7:0]            ram_data_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_rw
);
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t                state, next_state;
  logic [ADDR_WIDTH-1:0] base, cur_addr;
  logic [2:0]            n, idx;
  logic [31:0]           wdata, rbuf, rbuf_next, if_data_q, mem_rdata_q;
  logic                  owner_mem, cap_pend;
  logic [1:0]            cap_lane;
  logic                  accept_mem, accept_if, mem_valid, issue, io_block;

  function automatic logic [2:0] width_to_n(input logic [1:0] w);
    case (w)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    issue      = 1'b0;
    accept_mem = 1'b0;
    accept_if  = 1'b0;
    ram_addr_o = '0;
    ram_data_o = '0;
    ram_rw     = 1'b0;
    mem_valid  = (bus.mem_req == 2'b01) || (bus.mem_req == 2'b10);
    cur_addr   = base + ADDR_WIDTH'(idx);
`ifdef MEM_ARB_IO_WAIT_EN
    io_block   = io_buffer_full && (cur_addr[17:16] == IO_SEL);
`else
    // Feature compiled out: operands stay referenced but the stall is masked off.
    io_block   = io_buffer_full & (cur_addr[17:16] == IO_SEL) & 1'b0;
`endif
    // Read data lands one cycle after its address; fold any owed byte into its lane.
    rbuf_next = rbuf;
    if (cap_pend) rbuf_next[{cap_lane, 3'b000} +: 8] = ram_data_i;

    case (state)
      IDLE: begin
        if (rdy) begin
          if (mem_valid) begin
            accept_mem = 1'b1;
            next_state = (bus.mem_req == 2'b10) ? WR : RD;
          end else if (bus.if_req) begin
            accept_if  = 1'b1;
            next_state = RD;
          end
        end
      end
      RD: begin
        if (idx == n) begin
          next_state = DONE;
        end else if (rdy) begin
          issue      = 1'b1;
          ram_addr_o = cur_addr;
        end
      end
      WR: begin
        if (rdy && !io_block) begin
          issue      = 1'b1;
          ram_rw     = 1'b1;
          ram_addr_o = cur_addr;
          ram_data_o = wdata[{idx[1:0], 3'b000} +: 8];
          if (idx + 3'd1 == n) next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base        <= '0;
      n           <= '0;
      idx         <= '0;
      wdata       <= '0;
      owner_mem   <= 1'b0;
      cap_pend    <= 1'b0;
      cap_lane    <= '0;
      rbuf        <= '0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
    end else begin
      rbuf     <= rbuf_next;
      cap_pend <= issue && (state == RD);
      if (issue) begin
        cap_lane <= idx[1:0];
        idx      <= idx + 3'd1;
      end
      if (accept_mem || accept_if) begin
        idx       <= '0;
        rbuf      <= '0;
        owner_mem <= accept_mem;
      end
      if (accept_mem) begin
        base  <= bus.mem_addr;
        n     <= width_to_n(bus.mem_width);
        wdata <= bus.mem_wdata;
      end else if (accept_if) begin
        base <= bus.if_addr;
        n    <= 3'd4;
      end
      if (state == RD && next_state == DONE) begin
        if (owner_mem) mem_rdata_q <= rbuf_next;
        else           if_data_q   <= rbuf_next;
      end
    end
  end

  assign busy          = (state != IDLE);
  assign bus.if_done   = (state == DONE) && !owner_mem;
  assign bus.mem_done  = (state == DONE) && owner_mem;
  assign bus.if_data   = if_data_q;
  assign bus.mem_rdata = mem_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of single transactions plus hand-written
// sequences for arbitration, rdy stall, mid-transaction reset and the IO write wait.
module tb_mem_arbiter;
  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          rst, rdy, io_buffer_full, busy, ram_rw;
  logic [7:0]    ram_data_i, ram_data_o;
  logic [AW-1:0] ram_addr_o;

  mem_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

  mem_arbiter #(.ADDR_WIDTH(AW), .IO_SEL(2'b11)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .bus(bus), .busy(busy),
    .io_buffer_full(io_buffer_full), .ram_data_i(ram_data_i),
    .ram_data_o(ram_data_o), .ram_addr_o(ram_addr_o), .ram_rw(ram_rw)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Sparse RAM: preset bytes come from rom(), written bytes override them.
  logic [7:0] ram     [0:8191];
  bit         written [0:8191];

  function automatic int unsigned ridx(input logic [31:0] a);
    return {19'd0, a[17:16], a[10:0]};
  endfunction

  function automatic logic [7:0] rom(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 8'h93;
      32'h0000_0002: return 8'h10;
      32'h0000_0004: return 8'h13;
      32'h0000_0005: return 8'h05;
      32'h0000_0040: return 8'h11;
      32'h0000_0041: return 8'h22;
      32'h0000_0042: return 8'h33;
      32'h0000_0043: return 8'h44;
      32'h0000_0051: return 8'hCD;
      32'h0000_0052: return 8'hEF;
      32'h0000_0100: return 8'hAB;
      32'hFFFF_FFFE: return 8'hA1;
      32'hFFFF_FFFF: return 8'hB2;
      default:       return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    return written[ridx(a)] ? ram[ridx(a)] : rom(a);
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_rw) begin
      ram[ridx(ram_addr_o)]     <= ram_data_o;
      written[ridx(ram_addr_o)] <= 1'b1;
    end
    ram_data_i <= mem_rd(ram_addr_o);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          fetch;
    logic [1:0]  req;
    logic [31:0] addr;
    logic [1:0]  width;
    logic [31:0] wdata;
    int          n;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  // Called just after a rising edge in an IDLE cycle (T0). Checks the RAM pins every cycle
  // against the expected byte schedule and returns done latency and result word.
  task automatic run_op(input vec_t v, input int stall_k, input int stall_len, input int io_len,
                        output int lat, output logic [31:0] res, output bit pins_ok);
    int          issued;
    bit          blk, iss, st;
    logic [31:0] ea;
    lat = -1; res = '0; pins_ok = 1'b1; issued = 0;
    st = !v.fetch && (v.req == 2'b10);
    if (v.fetch) begin
      bus.if_req = 1'b1; bus.if_addr = v.addr;
    end else begin
      bus.mem_req = v.req; bus.mem_addr = v.addr; bus.mem_width = v.width; bus.mem_wdata = v.wdata;
    end
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(posedge clk); #1;
      rdy            = !(k >= stall_k && k < stall_k + stall_len);
      io_buffer_full = (k <= io_len);
      @(negedge clk);
      ea  = v.addr + 32'(issued);
      blk = 1'b0;
`ifdef MEM_ARB_IO_WAIT_EN
      blk = st && io_buffer_full && (ea[17:16] == 2'b11);
`endif
      iss = (issued < v.n) && rdy && !blk;
      if (ram_rw !== (iss && st) || ram_addr_o !== (iss ? ea : 32'h0)) pins_ok = 1'b0;
      if (iss && st) begin
        if (ram_data_o !== v.wdata[8*issued +: 8]) pins_ok = 1'b0;
        res[8*issued +: 8] = ram_data_o;
      end else if (ram_data_o !== 8'h00) begin
        pins_ok = 1'b0;
      end
      if (iss) issued++;
      if (v.fetch ? bus.mem_done : bus.if_done) pins_ok = 1'b0;
      if (v.fetch ? bus.if_done : bus.mem_done) begin
        lat = k;
        if (v.fetch)  res = bus.if_data;
        else if (!st) res = bus.mem_rdata;
        bus.if_req = 1'b0; bus.mem_req = 2'b00;
        rdy = 1'b1; io_buffer_full = 1'b0;
      end
    end
    bus.if_req = 1'b0; bus.mem_req = 2'b00; rdy = 1'b1; io_buffer_full = 1'b0;
  endtask

  vec_t        vt [12];
  vec_t        v;
  int          lat, t0, mlat, ilat;
  logic [31:0] res, mdat, idat;
  bit          pok, seen;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{1'b1, 2'b00, 32'h0000_0004, 2'b10, 32'h0,          4, 32'h0000_0513, 6};
    vt[1]  = '{1'b0, 2'b01, 32'h0000_0100, 2'b00, 32'h0,          1, 32'h0000_00AB, 3};
    vt[2]  = '{1'b0, 2'b01, 32'h0000_0051, 2'b01, 32'h0,          2, 32'h0000_EFCD, 4};
    vt[3]  = '{1'b0, 2'b01, 32'h0000_0040, 2'b10, 32'h0,          4, 32'h4433_2211, 6};
    vt[4]  = '{1'b0, 2'b01, 32'h0000_0040, 2'b11, 32'h0,          4, 32'h4433_2211, 6};
    vt[5]  = '{1'b0, 2'b01, 32'hFFFF_FFFE, 2'b10, 32'h0,          4, 32'h0093_B2A1, 6};
    vt[6]  = '{1'b0, 2'b10, 32'h0000_0200, 2'b01, 32'h0000_BEEF,  2, 32'h0000_BEEF, 3};
    vt[7]  = '{1'b0, 2'b10, 32'h0000_0300, 2'b00, 32'h1234_5678,  1, 32'h0000_0078, 2};
    vt[8]  = '{1'b0, 2'b10, 32'h0000_0400, 2'b10, 32'hCAFE_F00D,  4, 32'hCAFE_F00D, 5};
    vt[9]  = '{1'b1, 2'b00, 32'h0000_0000, 2'b10, 32'h0,          4, 32'h0010_0093, 6};
    vt[10] = '{1'b0, 2'b01, 32'h0000_0201, 2'b00, 32'h0,          1, 32'h0000_00BE, 3};
    vt[11] = '{1'b0, 2'b01, 32'h0000_0402, 2'b01, 32'h0,          2, 32'h0000_CAFE, 4};

    rst = 1'b1; rdy = 1'b1; io_buffer_full = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.mem_req = 2'b00; bus.mem_addr = '0; bus.mem_width = 2'b00; bus.mem_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_addr", ram_addr_o, 32'h0);
    chk("rst_rw", 32'(ram_rw), 32'h0);
    chk("rst_wdata", 32'(ram_data_o), 32'h0);
    chk("rst_dones", {30'd0, bus.if_done, bus.mem_done}, 32'h0);
    chk("rst_ifdata", bus.if_data, 32'h0);
    chk("rst_memrdata", bus.mem_rdata, 32'h0);
    rst = 1'b0;

    foreach (vt[i]) begin
      @(posedge clk); #1;
      run_op(vt[i], 0, 0, 0, lat, res, pok);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vt[i].lat));
      chk($sformatf("vec%0d_data", i), res, vt[i].exp);
      chk($sformatf("vec%0d_pins", i), 32'(pok), 32'h1);
    end
    chk("store_mem_200", 32'(mem_rd(32'h200)), 32'hEF);
    chk("store_mem_403", 32'(mem_rd(32'h403)), 32'hCA);
    chk("store_mem_301_untouched", 32'(mem_rd(32'h301)), 32'h00);

    // MEM and IF requested together: MEM byte load first, then the fetch.
    @(posedge clk); #1;
    t0 = cyc; mlat = -1; ilat = -1; mdat = '0; idat = '0;
    bus.if_req = 1'b1; bus.if_addr = 32'h0;
    bus.mem_req = 2'b01; bus.mem_addr = 32'h100; bus.mem_width = 2'b00;
    for (int k = 0; k < 30 && ilat < 0; k++) begin
      @(negedge clk);
      if (bus.mem_done) begin mlat = cyc - t0; mdat = bus.mem_rdata; bus.mem_req = 2'b00; end
      if (bus.if_done)  begin ilat = cyc - t0; idat = bus.if_data;   bus.if_req = 1'b0; end
    end
    bus.if_req = 1'b0; bus.mem_req = 2'b00;
    chk("tie_mem_latency", 32'(mlat), 32'd3);
    chk("tie_mem_data", mdat, 32'h0000_00AB);
    chk("tie_if_latency", 32'(ilat), 32'd10);
    chk("tie_if_data", idat, 32'h0010_0093);

    // rdy low for two cycles after the second issue of a word load.
    @(posedge clk); #1;
    v = vt[3];
    run_op(v, 3, 2, 0, lat, res, pok);
    chk("stall_latency", 32'(lat), 32'd8);
    chk("stall_data", res, 32'h4433_2211);
    chk("stall_pins", 32'(pok), 32'h1);

    // Reset while the third byte of a word store is on the pins.
    @(posedge clk); #1;
    bus.mem_req = 2'b10; bus.mem_addr = 32'h500; bus.mem_width = 2'b10; bus.mem_wdata = 32'hDDCC_BBAA;
    repeat (3) begin @(posedge clk); #1; end
    chk("rstmid_pre_addr", ram_addr_o, 32'h502);
    chk("rstmid_pre_rw", 32'(ram_rw), 32'h1);
    #2 rst = 1'b1; bus.mem_req = 2'b00;
    #1;
    chk("rstmid_addr", ram_addr_o, 32'h0);
    chk("rstmid_rw_data", {23'd0, ram_rw, ram_data_o}, 32'h0);
    chk("rstmid_busy", 32'(busy), 32'h0);
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.mem_done || bus.if_done || busy) seen = 1'b1;
    end
    chk("rstmid_no_done", 32'(seen), 32'h0);
    chk("rstmid_mem_500", 32'(mem_rd(32'h500)), 32'hAA);
    chk("rstmid_mem_501", 32'(mem_rd(32'h501)), 32'hBB);
    chk("rstmid_mem_502", 32'(mem_rd(32'h502)), 32'h00);
    chk("rstmid_rdata_cleared", bus.mem_rdata, 32'h0);

    // Byte store into the IO region with io_buffer_full high for three cycles.
    @(posedge clk); #1;
    v = '{1'b0, 2'b10, 32'h0003_0000, 2'b00, 32'h0000_0041, 1, 32'h0000_0041, 0};
`ifdef MEM_ARB_IO_WAIT_EN
    v.lat = 5;
`else
    v.lat = 2;
`endif
    run_op(v, 0, 0, 3, lat, res, pok);
    chk("io_latency", 32'(lat), 32'(v.lat));
    chk("io_data", res, 32'h0000_0041);
    chk("io_pins", 32'(pok), 32'h1);
    chk("io_mem", 32'(mem_rd(32'h30000)), 32'h41);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
